// File: rtl/pcieifc_fifo_pkg.sv
// Shared definitions for the PCIe interface async FIFO read-side logic.
// Level encoding is used by both the skid buffer and the consume-strobe logic.
package pcieifc_fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 128;

    localparam logic [1:0] LVL_EMPTY = 2'd0;
    localparam logic [1:0] LVL_ONE   = 2'd1;
    localparam logic [1:0] LVL_FULL  = 2'd2;

    function automatic logic lvl_has_room(input logic [1:0] lvl);
        return (lvl != LVL_FULL);
    endfunction

endpackage

// File: rtl/pcieifc_skid_buf2.sv
// Two-entry valid/ready buffer with level output. Entry 0 is always the head.
// A push with the buffer full and no pop is ignored; the producer must not issue one.
module pcieifc_skid_buf2
    import pcieifc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_level
);

    logic [1:0]            r_level;
    logic [DATA_WIDTH-1:0] r_ent0;
    logic [DATA_WIDTH-1:0] r_ent1;

    logic                  w_pop;
    logic [1:0]            w_level_nxt;
    logic [DATA_WIDTH-1:0] w_ent0_nxt;
    logic [DATA_WIDTH-1:0] w_ent1_nxt;

    // Handshake: a word transfers on any rising edge where o_valid and i_pop_ready are both 1;
    // o_valid/o_data come straight from registers and hold until that transfer.
    assign w_pop = (r_level != LVL_EMPTY) && i_pop_ready;

    always_comb begin
        w_level_nxt = r_level;
        w_ent0_nxt  = r_ent0;
        w_ent1_nxt  = r_ent1;
        if (i_clear) begin
            w_level_nxt = LVL_EMPTY;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_level == LVL_EMPTY) begin
                        w_ent0_nxt  = i_push_data;
                        w_level_nxt = LVL_ONE;
                    end else if (r_level == LVL_ONE) begin
                        w_ent1_nxt  = i_push_data;
                        w_level_nxt = LVL_FULL;
                    end
                end
                2'b01: begin
                    w_ent0_nxt  = r_ent1;
                    w_level_nxt = r_level - 2'd1;
                end
                2'b11: begin
                    // Level is unchanged; the head advances and the new word fills the freed slot.
                    if (r_level == LVL_ONE) begin
                        w_ent0_nxt = i_push_data;
                    end else begin
                        w_ent0_nxt = r_ent1;
                        w_ent1_nxt = i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= LVL_EMPTY;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else begin
            r_level <= w_level_nxt;
            r_ent0  <= w_ent0_nxt;
            r_ent1  <= w_ent1_nxt;
        end
    end

    assign o_valid = (r_level != LVL_EMPTY);
    assign o_data  = r_ent0;
    assign o_level = r_level;

endmodule

// File: rtl/pcieifc_fifo_rd_stage.sv
// Read-side output stage of the PCIe async FIFO: turns the controller's first-word-fall-through
// head (empty flag + RAM data + consume strobe) into a registered valid/ready stream.
module pcieifc_fifo_rd_stage
    import pcieifc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  fifo_clk,
    input  logic                  fifo_rstn,
    input  logic                  fifo_clear,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_inc,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            out_level
);

    logic       r_run;
    logic [1:0] w_level;
    logic       w_inc;

    // r_run is low throughout reset, so fifo_inc drops the instant fifo_rstn asserts
    // even though fifo_empty is driven by the other block.
    always_ff @(posedge fifo_clk or negedge fifo_rstn) begin
        if (!fifo_rstn) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Depends only on registers (r_run, buffer level, controller's empty flag) and the flush,
    // never on out_ready; room is checked against the current level so the buffer cannot overflow.
    assign w_inc = r_run && !fifo_empty && lvl_has_room(w_level) && !fifo_clear;

    // The RAM head is valid in the same cycle as the strobe, so the word is captured directly.
    pcieifc_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk       (fifo_clk),
        .i_rst_n     (fifo_rstn),
        .i_clear     (fifo_clear),
        .i_push      (w_inc),
        .i_push_data (fifo_rdata),
        .i_pop_ready (out_ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_level     (w_level)
    );

    assign fifo_inc  = w_inc;
    assign out_level = w_level;

endmodule

// File: tb/tb_pcieifc_fifo_rd_stage.sv
// Bench for pcieifc_fifo_rd_stage: a queue-based read controller model feeds words, a scoreboard
// holds every consumed word in order, and outputs are compared against it each cycle.
`timescale 1ns/1ps
module tb_pcieifc_fifo_rd_stage;

  localparam int DW = 128;

  logic          fifo_clk;
  logic          fifo_rstn;
  logic          fifo_clear;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_inc;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    out_level;

  pcieifc_fifo_rd_stage #(.DATA_WIDTH(DW)) dut (
    .fifo_clk   (fifo_clk),
    .fifo_rstn  (fifo_rstn),
    .fifo_clear (fifo_clear),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_inc   (fifo_inc),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_level  (out_level)
  );

  // clock
  initial fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_on = 0;
  int rdy_mode = 0;   // 0: never ready, 1: always ready, 2: random 50%
  int gap_pct = 0;
  int n_inc, n_pop, max_lvl;
  int first_inc_cyc, first_val_cyc, first_pop_cyc, last_pop_cyc;
  logic [DW-1:0] last_pop_data;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_inc = 0; n_pop = 0; max_lvl = 0;
    first_inc_cyc = -1; first_val_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
  endtask

  // One clock cycle: sample at the falling edge, update the model, then drive after the rising edge.
  task automatic tick();
    bit inc_s, pop_s, gap;
    @(negedge fifo_clk);
    cyc++;
    inc_s = fifo_inc;
    pop_s = out_valid && out_ready;
    if (chk_on) begin
      chk("level", {126'd0, out_level}, exp_q.size());
      chk("valid", {127'd0, out_valid}, {127'd0, exp_q.size() != 0});
      chk("inc_rule", {127'd0, fifo_inc}, {127'd0, !fifo_empty && exp_q.size() < 2 && !fifo_clear});
      if (out_valid) begin
        if (exp_q.size() != 0) chk("data", out_data, exp_q[0]);
        else chk("data_nothing_expected", {127'd0, out_valid}, '0);
      end
    end
    if (int'(out_level) > max_lvl) max_lvl = int'(out_level);
    if (inc_s && first_inc_cyc < 0) first_inc_cyc = cyc;
    if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (pop_s) begin
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      last_pop_data = out_data;
      n_pop++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (inc_s) begin
      n_inc++;
      exp_q.push_back(fifo_rdata);
      if (src_q.size() != 0) void'(src_q.pop_front());
    end
    if (fifo_clear) exp_q.delete();
    @(posedge fifo_clk);
    #1;
    fifo_clear = 1'b0;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = $urandom_range(1);
    endcase
    // A presented, unconsumed word stays presented; gaps only appear before a new head.
    if (!(fifo_empty == 1'b0 && !inc_s)) begin
      gap = ($urandom_range(99) < gap_pct);
      if (src_q.size() == 0 || gap) begin
        fifo_empty = 1'b1;
        fifo_rdata = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        fifo_empty = 1'b0;
        fifo_rdata = src_q[0];
      end
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int k;
    k = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_drained"}, {127'd0, (src_q.size() == 0 && exp_q.size() == 0)}, 128'd1);
  endtask

  initial begin
    int k;
    fifo_rstn = 1'b0; fifo_clear = 1'b0; fifo_empty = 1'b1;
    fifo_rdata = '0; out_ready = 1'b0;
    clr_stats();

    // Reset values
    #1;
    chk("rst_inc", {127'd0, fifo_inc}, '0);
    chk("rst_valid", {127'd0, out_valid}, '0);
    chk("rst_level", {126'd0, out_level}, '0);
    chk("rst_data", out_data, '0);
    repeat (2) @(posedge fifo_clk);
    #1 fifo_rstn = 1'b1;
    chk_on = 1;

    // Idle with empty FIFO
    repeat (20) tick();
    chk("idle_no_inc", {127'd0, n_inc != 0}, '0);

    // 8 back-to-back words, always ready
    clr_stats();
    rdy_mode = 1; gap_pct = 0;
    for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
    k = 0;
    while (n_pop < 8 && k < 40) begin tick(); k++; end
    chk("b2b_pops", n_pop, 8);
    chk("b2b_first_latency", first_val_cyc - first_inc_cyc, 1);
    chk("b2b_consecutive", last_pop_cyc - first_pop_cyc, 7);
    chk("b2b_max_level", max_lvl, 1);
    chk("b2b_last_word", last_pop_data, 128'h8);
    tick();

    // 8 words, output stalled
    clr_stats();
    rdy_mode = 0;
    for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
    repeat (10) tick();
    chk("stall_inc_pulses", n_inc, 2);
    chk("stall_level", {126'd0, out_level}, 128'd2);
    chk("stall_data_held", out_data, 128'h1);
    rdy_mode = 1;
    drain(60, "stall");
    chk("stall_total_pops", n_pop, 8);
    chk("stall_last_word", last_pop_data, 128'h8);

    // Random ready and gaps, 1000 words
    clr_stats();
    rdy_mode = 2; gap_pct = 30;
    for (int i = 0; i < 1000; i++) src_q.push_back({$urandom, $urandom, $urandom, $urandom});
    drain(20000, "random");
    chk("random_pops", n_pop, 1000);
    chk("random_level_range", {127'd0, max_lvl <= 2}, 128'd1);
    repeat (2) tick();

    // Flush with two words buffered
    clr_stats();
    rdy_mode = 0; gap_pct = 0;
    src_q.push_back(128'hA);
    src_q.push_back(128'hB);
    k = 0;
    while (n_inc < 2 && k < 10) begin tick(); k++; end
    tick();
    chk("flush_pre_level", {126'd0, out_level}, 128'd2);
    chk("flush_pre_data", out_data, 128'hA);
    fifo_clear = 1'b1;
    tick();
    chk("flush_valid", {127'd0, out_valid}, '0);
    chk("flush_level", {126'd0, out_level}, '0);
    chk("flush_inc", {127'd0, fifo_inc}, '0);
    src_q.push_back(128'hC);
    rdy_mode = 1;
    clr_stats();
    k = 0;
    while (n_pop < 1 && k < 10) begin tick(); k++; end
    chk("flush_first_after", last_pop_data, 128'hC);
    drain(10, "flush");

    // Asynchronous reset mid-stream at level 1
    for (int i = 0; i < 50; i++) src_q.push_back(DW'(32'h100 + i));
    repeat (10) tick();
    chk("arst_pre_level", {126'd0, out_level}, 128'd1);
    chk("arst_pre_inc", {127'd0, fifo_inc}, 128'd1);
    #2;
    fifo_rstn = 1'b0;
    #1;
    chk("arst_inc", {127'd0, fifo_inc}, '0);
    chk("arst_valid", {127'd0, out_valid}, '0);
    chk("arst_level", {126'd0, out_level}, '0);
    chk("arst_data", out_data, '0);
    src_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    @(posedge fifo_clk);
    #1 fifo_rstn = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
